// File: rtl/pkg_uart.sv
// rtl/pkg_uart.sv - shared constants and FSM state type for the UART transmitter
package pkg_uart;

   localparam int DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - byte FIFO with wrap-bit pointers and a dropped-write pulse
module uart_fifo
   import pkg_uart::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 wr_en,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic                 overflow_q, overflow_d;
   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic                 wr_ok;
   logic                 rd_ok;

   // full/empty come straight from registered pointers, so a write in the
   // same cycle as a pop still sees the old full flag and is rejected.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = wr_en && full;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8-bit UART transmitter with optional even parity
module uart_tx_fifo
   import pkg_uart::*;
#(
   parameter int BAUDRATE  = 434,
   parameter int DEPTH     = 4,
   parameter int PARITY_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 wr_en,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 busy,
   output logic                 tx
);

   localparam int CW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
   localparam int BW = $clog2(DATA_BITS);

   state_e               state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 pop;
   logic                 last;
   logic [DATA_BITS-1:0] head;

   uart_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (data_in),
      .wr_en    (wr_en),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
      .overflow (overflow)
   );

   assign last = (baud_q == CW'(BAUDRATE - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (last) begin
               baud_d = '0;
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (last) begin
               baud_d  = '0;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (last) begin
               baud_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line level is decoded from the next state so tx moves on the same
   // edge as the state register instead of lagging a cycle behind it.
   always_comb begin
      tx_d = LINE_IDLE;
      unique case (state_d)
         ST_IDLE:   tx_d = LINE_IDLE;
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[bit_d];
         ST_PARITY: tx_d = ^shift_d;
         ST_STOP:   tx_d = LINE_IDLE;
         default:   tx_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for the FIFO-buffered UART transmitter
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data0 = 8'h00;
   logic       wr0 = 1'b0;
   logic       full0, empty0, overflow0, busy0, tx0;
   logic [7:0] data1 = 8'h00;
   logic       wr1 = 1'b0;
   logic       full1, empty1, overflow1, busy1, tx1;

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic       mon_en = 1'b1;
   logic [7:0] sb[$];
   int         starts[$];

   uart_tx_fifo #(.BAUDRATE(4), .DEPTH(4), .PARITY_EN(1)) dut0 (
      .clk(clk), .rst(rst), .data_in(data0), .wr_en(wr0),
      .full(full0), .empty(empty0), .overflow(overflow0), .busy(busy0), .tx(tx0)
   );

   uart_tx_fifo #(.BAUDRATE(4), .DEPTH(4), .PARITY_EN(0)) dut1 (
      .clk(clk), .rst(rst), .data_in(data1), .wr_en(wr1),
      .full(full1), .empty(empty1), .overflow(overflow1), .busy(busy1), .tx(tx1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy0) && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", n >= budget, 0);
      step();
   endtask

   // Line decoder: samples mid-bit, checks data/parity/stop against the queue.
   initial begin : monitor
      logic [7:0] d;
      logic       par;
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && tx0 == 1'b0) begin
            starts.push_back(cyc);
            repeat (2) @(negedge clk);
            check("start_bit", tx0, 1'b0);
            for (int k = 0; k < 8; k++) begin
               repeat (4) @(negedge clk);
               d[k] = tx0;
            end
            repeat (4) @(negedge clk);
            par = tx0;
            repeat (4) @(negedge clk);
            check("stop_bit", tx0, 1'b1);
            if (sb.size() == 0) begin
               check("unexpected_frame", {24'h0, d}, 32'hffff_ffff);
            end else begin
               exp = sb.pop_front();
               check("frame_data", d, exp);
               check("frame_parity", par, ^exp);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int cnt;
      int errs;
      int lows;
      int ovf_cycles;

      repeat (3) step();
      check("rst_tx", tx0, 1'b1);
      check("rst_busy", busy0, 1'b0);
      check("rst_empty", empty0, 1'b1);
      check("rst_full", full0, 1'b0);
      check("rst_overflow", overflow0, 1'b0);
      rst = 1'b0;
      step();

      // single byte: latency and frame length
      sb.push_back(8'hA5);
      wr0 = 1'b1; data0 = 8'hA5;
      step();
      wr0 = 1'b0;
      check("lat_empty_n1", empty0, 1'b0);
      check("lat_tx_n1", tx0, 1'b1);
      step();
      check("lat_tx_n2", tx0, 1'b0);
      check("lat_busy_n2", busy0, 1'b1);
      cnt = 0;
      while (busy0 && cnt < 100) begin
         step();
         cnt++;
      end
      check("frame_len_a5", cnt, 44);
      wait_drain(500);

      // back-to-back frames
      starts.delete();
      for (int i = 0; i < 3; i++) begin
         data0 = (i == 0) ? 8'h01 : (i == 1) ? 8'h03 : 8'h07;
         sb.push_back(data0);
         wr0 = 1'b1;
         step();
      end
      wr0 = 1'b0;
      wait_drain(500);
      check("b2b_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         check("b2b_gap1", starts[1] - starts[0], 44);
         check("b2b_gap2", starts[2] - starts[1], 44);
      end

      // overfill: 6 writes, 5 accepted
      ovf_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         data0 = 8'h30 + 8'(i);
         if (i < 5) sb.push_back(data0);
         wr0 = 1'b1;
         step();
         check("fill_full", full0, (i >= 4));
         check("fill_overflow", overflow0, (i == 5));
         ovf_cycles += int'(overflow0);
      end
      wr0 = 1'b0;
      step();
      check("fill_overflow_end", overflow0, 1'b0);
      ovf_cycles += int'(overflow0);
      check("fill_overflow_cycles", ovf_cycles, 1);
      wait_drain(1000);

      // write while full in the same cycle as a pop
      for (int i = 0; i < 5; i++) begin
         data0 = 8'h40 + 8'(i);
         sb.push_back(data0);
         wr0 = 1'b1;
         step();
      end
      wr0 = 1'b0;
      repeat (40) step();
      check("pop_pre_full", full0, 1'b1);
      wr0 = 1'b1; data0 = 8'hEE;
      step();
      wr0 = 1'b0;
      check("pop_overflow", overflow0, 1'b1);
      check("pop_full", full0, 1'b0);
      check("pop_empty", empty0, 1'b0);
      wait_drain(1000);

      // reset in the middle of a frame with bytes queued
      mon_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data0 = (i == 0) ? 8'hFF : (i == 1) ? 8'h11 : 8'h22;
         wr0 = 1'b1;
         step();
      end
      wr0 = 1'b0;
      repeat (17) step();
      check("mid_busy", busy0, 1'b1);
      check("mid_empty", empty0, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", tx0, 1'b1);
      check("mid_rst_busy", busy0, 1'b0);
      check("mid_rst_empty", empty0, 1'b1);
      check("mid_rst_full", full0, 1'b0);
      repeat (3) step();
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (tx0 !== 1'b1 || busy0 !== 1'b0) lows++;
      end
      check("post_rst_silent", lows, 0);

      // first write right after reset release
      rst = 1'b1;
      step();
      mon_en = 1'b1;
      sb.push_back(8'h5A);
      rst = 1'b0; wr0 = 1'b1; data0 = 8'h5A;
      step();
      wr0 = 1'b0;
      check("first_wr_empty", empty0, 1'b0);
      wait_drain(500);

      // no-parity instance
      wr1 = 1'b1; data1 = 8'h80;
      step();
      wr1 = 1'b0;
      step();
      errs = 0;
      lows = 0;
      for (int c = 0; c < 40; c++) begin
         if (tx1 !== ((c < 32) ? 1'b0 : 1'b1)) errs++;
         if (busy1 !== 1'b1) lows++;
         step();
      end
      check("np_frame_bits", errs, 0);
      check("np_busy_in_frame", lows, 0);
      check("np_busy_end", busy1, 1'b0);
      check("np_tx_end", tx1, 1'b1);

      check("sb_leftover", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter BAUDRATE, default 434 (50000000/115200), clock cycles per UART bit.
REQ-002 Parameter DEPTH, default 4, FIFO entries; must be a power of two, at least 2.
REQ-003 Parameter PARITY_EN, default 1; 1 = even parity bit sent, 0 = no parity bit.
REQ-004 clk  input  1  single clock for the whole block; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 data_in  input  8  byte to transmit.
REQ-007 wr_en  input  1  write strobe for data_in, one byte per high cycle.
REQ-008 full  output  1  FIFO holds DEPTH bytes.
REQ-009 empty  output  1  FIFO holds 0 bytes.
REQ-010 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 busy  output  1  a frame is being transmitted.
REQ-012 tx  output  1  serial line, idle high, driven from a register.

Function
REQ-013 A write is accepted when wr_en=1 and full=0 at that clock edge; the byte is stored at the tail.
- full is the registered value, so a write while full is rejected even if the FSM pops in the same cycle.
REQ-014 A write with wr_en=1 and full=1 is dropped, the FIFO is unchanged, and overflow=1 for the next cycle only.
REQ-015 Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
- empty when the pointers are equal.
- full when the index bits are equal and the MSBs differ.
REQ-016 A simultaneous accepted write and pop leaves the occupancy unchanged.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
- Each state other than IDLE lasts exactly BAUDRATE cycles, timed by a baud counter running 0..BAUDRATE-1.
REQ-018 IDLE:
- tx=1, busy=0.
- If empty=0, pop the head byte into the shift register, clear the baud counter, and go to START.
REQ-019 START: tx=0; when the counter reaches BAUDRATE-1, go to DATA with bit index 0.
REQ-020 DATA:
- tx = shift-register bit, LSB first.
- After each bit period the index increments.
- After bit 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-021 PARITY: tx = XOR of the 8 data bits (even parity); then go to STOP.
REQ-022 STOP: tx=1 for one bit period. At the end of the period:
- if empty=0, pop and go directly to START (no idle gap);
- otherwise go to IDLE.
REQ-023 busy=1 in every state except IDLE.
REQ-024 Latency: a write in cycle N into an empty FIFO with the FSM in IDLE gives empty=0 in cycle N+1 and tx=0 from cycle N+2.
REQ-025 Frame length is 11*BAUDRATE cycles with PARITY_EN=1, 10*BAUDRATE cycles with PARITY_EN=0.
REQ-026 A byte popped into the shift register is unaffected by later FIFO writes.

Reset
REQ-027 While rst=1, and immediately on assertion, the block SHALL be in this state:
- FSM=IDLE, tx=1, busy=0;
- empty=1, full=0, overflow=0;
- pointers, baud counter and bit index = 0.
REQ-028 A reset asserted mid-frame aborts the frame; tx returns to 1 asynchronously and FIFO contents are discarded.
REQ-029 The first wr_en is honoured on the first rising edge after rst deasserts.

Structure
REQ-030 pkg_uart SHALL hold:
- the FSM state enum typedef;
- the constant DATA_BITS=8;
- the stop-bit and idle line level constant (1).
REQ-031 The FIFO is a separate sub-module, uart_fifo (parameter DEPTH, width 8). uart_tx_fifo holds the FSM, baud counter and shift register.

Verification
Benches use BAUDRATE=4, DEPTH=4, PARITY_EN=1 unless stated otherwise.
REQ-032 Write 0xA5 once. tx=0 from cycle N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), parity 0, stop 1, busy=0 after 44 cycles.
REQ-033 Write 0x01, 0x03, 0x07 on consecutive cycles. Three back-to-back 44-cycle frames with no idle gap; parity bits 1,0,1.
REQ-034 Write 6 bytes on consecutive cycles while the FSM is in IDLE.
- full=1 after the FSM has popped one byte and the FIFO holds 4.
- The 6th write gives an overflow pulse of exactly 1 cycle.
- The 5 accepted bytes are transmitted in order.
REQ-035 Assert rst during DATA bit 3 of 0xFF with 2 bytes still queued. tx=1 immediately, empty=1, busy=0, and no further frames are sent.
REQ-036 PARITY_EN=0, write 0x80. Frame is 40 cycles: start 0, seven 0 bits, one 1 bit, then stop 1.
REQ-037 With full=1, pulse wr_en in the cycle the FSM pops. The write is dropped, overflow pulses, and occupancy drops to 3.
